mem_stage: RTL and testbench

//  EX/MEM pipeline register plus data-memory access unit, directly downstream of exu.

---
 rtl/mem_stage.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   EX/MEM pipeline register and data-memory access unit, directly downstream
//   of exu. Captures the EX result/store data, runs the load/store bus
//   handshake, extracts and extends load data, and produces both the EX/MEM
//   forwarding view and a registered MEM/WB bundle. While an access is
//   outstanding the upstream pipeline is frozen via mem_stall.
//
// Build option:
//   MEM_MISALIGN_TRAP_EN  when defined, misaligned H/W accesses raise
//                         mem_misalign, skip the bus and suppress the rd
//                         write; when undefined, low address bits are ignored
//                         for lane selection and mem_misalign is tied 0.
//
// Parameters:
//   TIMEOUT_CYCLES  bus cycles without gnt/rvalid before abort (1..255)
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   exe_valid/result/...      instruction presented by EX
//   mem_stall                 freeze PC, IF/ID, ID/EX, EX inputs
//   mem_rd_idx/en/data        EX/MEM view for forwarding
//   dmem_*                    data bus (req/gnt, rvalid/rdata)
//   mem_bus_err               one-cycle pulse on access timeout
//   mem_misalign              misaligned access flag (trap build only)
//   wb_valid/rd_idx/en/data   MEM/WB register
//   dbg_state                 access FSM state (0 IDLE,1 REQ,2 WAIT,3 DONE)
//
// Bus handshake: dmem_req is a valid signal and dmem_gnt its ready; a
// request transfers in the cycle both are high, and addr/we/be/wdata are
// held unchanged from the first request cycle until that cycle. Load data
// transfers in the cycle dmem_rvalid is high, and is only accepted while
// waiting for it (rvalid is not back-pressured).
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_valid,
    input  logic [31:0] exe_result,
    input  logic [31:0] op_rs2,
    input  logic [4:0]  exe_rd_idx,
    input  logic        exe_rd_en,
    input  logic        exe_load,
    input  logic        exe_store,
    input  logic [2:0]  exe_funct3,
    output logic        mem_stall,
    output logic [4:0]  mem_rd_idx,
    output logic        mem_rd_en,
    output logic [31:0] mem_rd_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_bus_err,
    output logic        mem_misalign,
    output logic        wb_valid,
    output logic [4:0]  wb_rd_idx,
    output logic        wb_rd_en,
    output logic [31:0] wb_rd_data,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;

    // EX/MEM register
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [31:0] ex_rs2;
    logic [4:0]  ex_rd_idx;
    logic        ex_rd_en;
    logic        ex_load;
    logic        ex_store;
    logic [2:0]  ex_funct3;

    logic [7:0]  tmo_cnt;
    logic [31:0] ld_data;
    logic        bus_err_q;

    logic        misalign;
    logic        mem_op;
    logic        req_phase;
    logic        timeout_hit;
    logic        ld_capture;
    logic        cnt_clear;
    logic        is_word;
    logic        is_half;
    logic        is_unsigned;
    logic [1:0]  a_lo;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;

    assign a_lo        = ex_result[1:0];
    assign is_word     = ex_funct3[1];
    assign is_half     = ~ex_funct3[1] & ex_funct3[0];
    assign is_unsigned = ex_funct3[2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = ex_valid & (ex_load | ex_store) &
                      ((is_half & a_lo[0]) | (is_word & (a_lo != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // A trapped misaligned access is treated as a non-memory op: no bus
    // traffic and no stall.
    assign mem_op    = ex_valid & (ex_load | ex_store) & ~misalign;
    assign mem_stall = mem_op & (state != S_DONE);

    // ------------------------------------------------------------------
    // EX/MEM register: advances whenever the access unit is not stalling.
    // A bubble clears every field so downstream outputs read as zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_result <= '0;
            ex_rs2    <= '0;
            ex_rd_idx <= '0;
            ex_rd_en  <= 1'b0;
            ex_load   <= 1'b0;
            ex_store  <= 1'b0;
            ex_funct3 <= '0;
        end else if (!mem_stall) begin
            if (exe_valid) begin
                ex_valid  <= 1'b1;
                ex_result <= exe_result;
                ex_rs2    <= op_rs2;
                ex_rd_idx <= exe_rd_idx;
                ex_rd_en  <= exe_rd_en;
                ex_load   <= exe_load;
                ex_store  <= exe_store;
                ex_funct3 <= exe_funct3;
            end else begin
                ex_valid  <= 1'b0;
                ex_result <= '0;
                ex_rs2    <= '0;
                ex_rd_idx <= '0;
                ex_rd_en  <= 1'b0;
                ex_load   <= 1'b0;
                ex_store  <= 1'b0;
                ex_funct3 <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Access FSM. The request is raised combinationally from IDLE in the
    // first cycle the instruction sits in EX/MEM, so a grant in that same
    // cycle costs no extra stall; REQ covers the following wait-for-grant
    // cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req_phase   = 1'b0;
        timeout_hit = 1'b0;
        ld_capture  = 1'b0;
        cnt_clear   = 1'b0;
        case (state)
            S_IDLE, S_REQ: begin
                if (mem_op) begin
                    req_phase = 1'b1;
                    if (dmem_gnt) begin
                        cnt_clear  = 1'b1;
                        state_next = ex_store ? S_DONE : S_WAIT;
                    end else if (tmo_cnt == TO_LAST) begin
                        timeout_hit = 1'b1;
                        state_next  = S_DONE;
                    end else begin
                        state_next = S_REQ;
                    end
                end else begin
                    cnt_clear  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid) begin
                    ld_capture = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = S_DONE;
                end else if (tmo_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = S_DONE;
                end
            end
            S_DONE: begin
                // DONE never stalls, so the pipe always advances out of it.
                cnt_clear  = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Counts bus cycles without progress; a grant restarts the budget for
    // the data phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (cnt_clear || timeout_hit) begin
            tmo_cnt <= '0;
        end else if (req_phase || (state == S_WAIT)) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Load extraction: lane chosen by the low address bits, then sign- or
    // zero-extended according to funct3[2].
    // ------------------------------------------------------------------
    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (a_lo)
            2'd0: ld_byte = dmem_rdata[7:0];
            2'd1: ld_byte = dmem_rdata[15:8];
            2'd2: ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = a_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (is_word) begin
            ld_ext = dmem_rdata;
        end else if (is_half) begin
            ld_ext = {{16{~is_unsigned & ld_half[15]}}, ld_half};
        end else begin
            ld_ext = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_data   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout_hit;
            if (ld_capture) begin
                ld_data <= ld_ext;
            end else if (timeout_hit) begin
                ld_data <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Store lanes. Halfwords use only a[1]; a[0] is either trapped or
    // deliberately ignored.
    // ------------------------------------------------------------------
    always_comb begin
        if (is_word) begin
            lane_be    = 4'b1111;
            lane_wdata = ex_rs2;
        end else if (is_half) begin
            lane_be    = a_lo[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{ex_rs2[15:0]}};
        end else begin
            lane_be    = 4'b0001 << a_lo;
            lane_wdata = {4{ex_rs2[7:0]}};
        end
    end

    assign dmem_req   = req_phase;
    assign dmem_we    = req_phase & ex_store;
    assign dmem_addr  = req_phase ? {ex_result[31:2], 2'b00} : 32'h0;
    assign dmem_be    = req_phase ? lane_be : 4'b0000;
    assign dmem_wdata = (req_phase & ex_store) ? lane_wdata : 32'h0;

    // ------------------------------------------------------------------
    // EX/MEM forwarding view
    // ------------------------------------------------------------------
    assign mem_rd_idx   = ex_rd_idx;
    assign mem_rd_en    = ex_valid & ex_rd_en & ~mem_stall & ~misalign;
    assign mem_rd_data  = (ex_load && (state == S_DONE)) ? ld_data : ex_result;
    assign mem_bus_err  = bus_err_q;
    assign mem_misalign = misalign;
    assign dbg_state    = state;

    // ------------------------------------------------------------------
    // MEM/WB register: a stalled cycle or an EX/MEM bubble writes a bubble.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_rd_idx  <= '0;
            wb_rd_en   <= 1'b0;
            wb_rd_data <= '0;
        end else if (!mem_stall && ex_valid) begin
            wb_valid   <= 1'b1;
            wb_rd_idx  <= ex_rd_idx;
            wb_rd_en   <= mem_rd_en;
            wb_rd_data <= mem_rd_data;
        end else begin
            wb_valid   <= 1'b0;
            wb_rd_idx  <= '0;
            wb_rd_en   <= 1'b0;
            wb_rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//   Directed bench for mem_stage. Inputs change and outputs are sampled just
//   after the falling edge; the rising edge is the active edge. Writebacks
//   are checked against a queue of expected {rd_idx, data} entries.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exe_valid = 1'b0;
    logic [31:0] exe_result = '0;
    logic [31:0] op_rs2 = '0;
    logic [4:0]  exe_rd_idx = '0;
    logic        exe_rd_en = 1'b0;
    logic        exe_load = 1'b0;
    logic        exe_store = 1'b0;
    logic [2:0]  exe_funct3 = '0;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    logic        mem_stall;
    logic [4:0]  mem_rd_idx;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        mem_bus_err;
    logic        mem_misalign;
    logic        wb_valid;
    logic [4:0]  wb_rd_idx;
    logic        wb_rd_en;
    logic [31:0] wb_rd_data;
    logic [1:0]  dbg_state;

    int          checks = 0;
    int          failures = 0;
    logic [36:0] exp_q[$];

    mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .exe_valid    (exe_valid),
        .exe_result   (exe_result),
        .op_rs2       (op_rs2),
        .exe_rd_idx   (exe_rd_idx),
        .exe_rd_en    (exe_rd_en),
        .exe_load     (exe_load),
        .exe_store    (exe_store),
        .exe_funct3   (exe_funct3),
        .mem_stall    (mem_stall),
        .mem_rd_idx   (mem_rd_idx),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_data  (mem_rd_data),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .mem_bus_err  (mem_bus_err),
        .mem_misalign (mem_misalign),
        .wb_valid     (wb_valid),
        .wb_rd_idx    (wb_rd_idx),
        .wb_rd_en     (wb_rd_en),
        .wb_rd_data   (wb_rd_data),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next sampling point and score any writeback.
    task automatic tick();
        logic [36:0] e;
        @(negedge clk);
        #1;
        if (wb_valid && wb_rd_en) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL wb_unexpected observed_rd=%0d observed_data=%h expected=none",
                       wb_rd_idx, wb_rd_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wb_rd_idx", 32'(wb_rd_idx), 32'(e[36:32]));
                chk("wb_rd_data", wb_rd_data, e[31:0]);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present one instruction for a single capture edge, then a bubble.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] res, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic rd_en);
        exe_valid  = 1'b1;
        exe_load   = ld;
        exe_store  = st;
        exe_funct3 = f3;
        exe_result = res;
        op_rs2     = rs2;
        exe_rd_idx = rd;
        exe_rd_en  = rd_en;
        tick();
        exe_valid  = 1'b0;
        exe_load   = 1'b0;
        exe_store  = 1'b0;
        exe_funct3 = '0;
        exe_result = '0;
        op_rs2     = '0;
        exe_rd_idx = '0;
        exe_rd_en  = 1'b0;
    endtask

    // Serve the bus: gnt in cycle g, rvalid in cycle r (cycle 0 is the
    // first cycle in EX/MEM; -1 means never). Returns the stall count.
    task automatic run_access(input int g, input int r, input logic [31:0] rdata,
                              output int stalls);
        int          cyc;
        bit          seen;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] w0;
        cyc    = 0;
        stalls = 0;
        seen   = 1'b0;
        a0     = '0;
        be0    = '0;
        w0     = '0;
        while (mem_stall && cyc < 40) begin
            if (dmem_req) begin
                if (!seen) begin
                    a0   = dmem_addr;
                    be0  = dmem_be;
                    w0   = dmem_wdata;
                    seen = 1'b1;
                end else begin
                    chk("req_addr_hold", dmem_addr, a0);
                    chk("req_be_hold", 32'(dmem_be), 32'(be0));
                    chk("req_wdata_hold", dmem_wdata, w0);
                end
            end
            stalls++;
            dmem_gnt    = (cyc == g);
            dmem_rvalid = (cyc == r);
            dmem_rdata  = (cyc == r) ? rdata : 32'h0;
            tick();
            cyc++;
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          st;
        logic [31:0] rnd_d;
        logic [31:0] rnd_s;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_mem_rd_data", mem_rd_data, 32'h0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd_data", wb_rd_data, 32'h0);
        chk("rst_bus_err", 32'(mem_bus_err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        tick();

        // ALU op: 1 cycle to EX/MEM, 1 more to MEM/WB, never stalls
        exp_q.push_back({5'd5, 32'h0000_1234});
        issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        chk("alu_stall", 32'(mem_stall), 32'd0);
        chk("alu_mem_rd_data", mem_rd_data, 32'h0000_1234);
        chk("alu_mem_rd_idx", 32'(mem_rd_idx), 32'd5);
        chk("alu_mem_rd_en", 32'(mem_rd_en), 32'd1);
        chk("alu_req", 32'(dmem_req), 32'd0);
        tick();
        chk("alu_wb_valid", 32'(wb_valid), 32'd1);

        // LB 0x103, gnt c0, rvalid c2 -> 3 stalls, 0xFFFF_FF80
        exp_q.push_back({5'd7, 32'hFFFF_FF80});
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
        chk("lb_req", 32'(dmem_req), 32'd1);
        chk("lb_we", 32'(dmem_we), 32'd0);
        chk("lb_addr", dmem_addr, 32'h0000_0100);
        chk("lb_be", 32'(dmem_be), 32'b1000);
        chk("lb_fwd_en", 32'(mem_rd_en), 32'd0);
        run_access(0, 2, 32'h80FF_0000, st);
        chk("lb_stalls", 32'(st), 32'd3);
        chk("lb_mem_rd_data", mem_rd_data, 32'hFFFF_FF80);
        chk("lb_mem_rd_en", 32'(mem_rd_en), 32'd1);

        // LH 0x206, gnt c0, rvalid c1 -> 2 stalls, upper half sign-extended
        exp_q.push_back({5'd8, 32'hFFFF_8765});
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0206, 32'h0, 5'd8, 1'b1);
        run_access(0, 1, 32'h8765_4321, st);
        chk("lh_stalls", 32'(st), 32'd2);

        // LHU 0x204, gnt c1, rvalid c3 -> 4 stalls, lower half zero-extended
        exp_q.push_back({5'd10, 32'h0000_8321});
        issue(1'b1, 1'b0, 3'b101, 32'h0000_0204, 32'h0, 5'd10, 1'b1);
        run_access(1, 3, 32'h8765_8321, st);
        chk("lhu_stalls", 32'(st), 32'd4);

        // LBU 0x101 -> lane 1 zero-extended
        exp_q.push_back({5'd3, 32'h0000_009A});
        issue(1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0, 5'd3, 1'b1);
        run_access(0, 1, 32'h1234_9A78, st);
        chk("lbu_stalls", 32'(st), 32'd2);

        // LW with random data
        rnd_d = $urandom_range(32'hFFFF_FFFF, 0);
        exp_q.push_back({5'd11, rnd_d});
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd11, 1'b1);
        chk("lw_be", 32'(dmem_be), 32'b1111);
        run_access(0, 1, rnd_d, st);
        chk("lw_stalls", 32'(st), 32'd2);

        // SH 0x102, rs2 0xABCD_1234, grant only in c1
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'hABCD_1234, 5'd0, 1'b0);
        chk("sh_req", 32'(dmem_req), 32'd1);
        chk("sh_we", 32'(dmem_we), 32'd1);
        chk("sh_addr", dmem_addr, 32'h0000_0100);
        chk("sh_be", 32'(dmem_be), 32'b1100);
        chk("sh_wdata", dmem_wdata, 32'h1234_1234);
        run_access(1, -1, 32'h0, st);
        chk("sh_stalls", 32'(st), 32'd2);
        chk("sh_req_done", 32'(dmem_req), 32'd0);
        tick();
        chk("sh_wb_valid", 32'(wb_valid), 32'd1);
        chk("sh_wb_rd_en", 32'(wb_rd_en), 32'd0);

        // SB 0x201 -> lane 1, replicated byte, 1 stall
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_005A, 5'd0, 1'b0);
        chk("sb_be", 32'(dmem_be), 32'b0010);
        chk("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
        run_access(0, -1, 32'h0, st);
        chk("sb_stalls", 32'(st), 32'd1);

        // SW random data
        rnd_s = $urandom_range(32'hFFFF_FFFF, 0);
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0204, rnd_s, 5'd0, 1'b0);
        chk("sw_be", 32'(dmem_be), 32'b1111);
        chk("sw_wdata", dmem_wdata, rnd_s);
        chk("sw_addr", dmem_addr, 32'h0000_0204);
        run_access(0, -1, 32'h0, st);
        chk("sw_stalls", 32'(st), 32'd1);

        // LW never granted -> abort after TMO cycles, data 0
        exp_q.push_back({5'd12, 32'h0});
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd12, 1'b1);
        chk("tmo_err_early", 32'(mem_bus_err), 32'd0);
        run_access(-1, -1, 32'h0, st);
        chk("tmo_stalls", 32'(st), 32'(TMO));
        chk("tmo_bus_err", 32'(mem_bus_err), 32'd1);
        chk("tmo_mem_rd_data", mem_rd_data, 32'h0);
        tick();
        chk("tmo_bus_err_pulse", 32'(mem_bus_err), 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
        // misaligned LW: flagged, no bus, no stall, no rd write
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd13, 1'b1);
        chk("mis_flag", 32'(mem_misalign), 32'd1);
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_stall", 32'(mem_stall), 32'd0);
        chk("mis_mem_rd_en", 32'(mem_rd_en), 32'd0);
        tick();
        chk("mis_wb_valid", 32'(wb_valid), 32'd1);
        chk("mis_wb_rd_en", 32'(wb_rd_en), 32'd0);
        chk("mis_flag_clear", 32'(mem_misalign), 32'd0);
`else
        // misaligned LW goes to the bus as an aligned word access
        exp_q.push_back({5'd13, 32'hCAFE_F00D});
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd13, 1'b1);
        chk("mis_flag", 32'(mem_misalign), 32'd0);
        chk("mis_req", 32'(dmem_req), 32'd1);
        chk("mis_addr", dmem_addr, 32'h0000_0100);
        chk("mis_be", 32'(dmem_be), 32'b1111);
        run_access(0, 1, 32'hCAFE_F00D, st);
        chk("mis_stalls", 32'(st), 32'd2);
        tick();
`endif

        // reset asserted while waiting for load data
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd14, 1'b1);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("rstw_in_wait", 32'(dbg_state), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("rstw_req", 32'(dmem_req), 32'd0);
        chk("rstw_wb_valid", 32'(wb_valid), 32'd0);
        chk("rstw_stall", 32'(mem_stall), 32'd0);
        chk("rstw_state", 32'(dbg_state), 32'd0);
        tick();
        rst = 1'b0;
        // late response after reset must be ignored
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
        tick();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        chk("rstw_late_state", 32'(dbg_state), 32'd0);
        chk("rstw_late_stall", 32'(mem_stall), 32'd0);
        tick();
        chk("rstw_late_wb", 32'(wb_valid), 32'd0);

        // drain and confirm every expected writeback was seen
        repeat (2) tick();
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
